// File: rtl/ex_alu_rs.sv
// ALU reservation station: buffers allocated ALU ops, snoops the result bus
// for locked operands, and issues the lowest-index fully unlocked entry per cycle.
module ex_alu_rs #(
  parameter int DEPTH = 4,
  parameter int OP_W  = 6,
  parameter int TAG_W = 4,
  parameter int REG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             alloc_en_in,
  input  logic [OP_W-1:0]  alloc_op_in,
  input  logic [TAG_W-1:0] alloc_tagx_in,
  input  logic [TAG_W-1:0] alloc_tagy_in,
  input  logic [TAG_W-1:0] alloc_tagw_in,
  input  logic [31:0]      alloc_datax_in,
  input  logic [31:0]      alloc_datay_in,
  input  logic [REG_W-1:0] alloc_target_in,
  input  logic [31:0]      alloc_pc_in,
  output logic             full_out,
  input  logic             cdb_en_in,
  input  logic [TAG_W-1:0] cdb_tag_in,
  input  logic [31:0]      cdb_data_in,
  input  logic             flush_in,
  output logic             alu_busy_out,
  output logic [OP_W-1:0]  alu_op_out,
  output logic [TAG_W-1:0] alu_tagx_out,
  output logic [TAG_W-1:0] alu_tagy_out,
  output logic [TAG_W-1:0] alu_tagw_out,
  output logic [31:0]      alu_datax_out,
  output logic [31:0]      alu_datay_out,
  output logic [REG_W-1:0] alu_target_out,
  output logic [31:0]      pc_out
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DEPTH-1:0] valid_q, valid_nxt, ready;
  logic [OP_W-1:0]  op_q     [DEPTH];
  logic [TAG_W-1:0] tagx_q   [DEPTH];
  logic [TAG_W-1:0] tagy_q   [DEPTH];
  logic [TAG_W-1:0] tagw_q   [DEPTH];
  logic [31:0]      datax_q  [DEPTH];
  logic [31:0]      datay_q  [DEPTH];
  logic [REG_W-1:0] target_q [DEPTH];
  logic [31:0]      pc_q     [DEPTH];

  logic             issue_found, alloc_found, alloc_ok;
  logic [IDX_W-1:0] issue_idx, alloc_idx;
  logic             hit_x, hit_y, hit_w;

  // Issued ops always carry resolved operands, so their tags are constant zero.
  assign alu_tagx_out = '0;
  assign alu_tagy_out = '0;
  assign alu_tagw_out = '0;

  always_comb begin
    for (int i = 0; i < DEPTH; i++)
      ready[i] = valid_q[i] && (tagx_q[i] == '0) && (tagy_q[i] == '0) && (tagw_q[i] == '0);
  end

  always_comb begin
    issue_found = 1'b0;
    issue_idx   = '0;
    alloc_found = 1'b0;
    alloc_idx   = '0;
    // Scan downward so the lowest matching index is the one left standing.
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (ready[i]) begin
        issue_found = 1'b1;
        issue_idx   = IDX_W'(i);
      end
      if (!valid_q[i]) begin
        alloc_found = 1'b1;
        alloc_idx   = IDX_W'(i);
      end
    end
    alloc_ok  = alloc_en_in && !full_out && alloc_found;
    valid_nxt = valid_q;
    if (issue_found) valid_nxt[issue_idx] = 1'b0;
    if (alloc_ok)    valid_nxt[alloc_idx] = 1'b1;
  end

  assign hit_x = cdb_en_in && (alloc_tagx_in == cdb_tag_in);
  assign hit_y = cdb_en_in && (alloc_tagy_in == cdb_tag_in);
  assign hit_w = cdb_en_in && (alloc_tagw_in == cdb_tag_in);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q        <= '0;
      full_out       <= 1'b0;
      alu_busy_out   <= 1'b0;
      alu_op_out     <= '0;
      alu_datax_out  <= '0;
      alu_datay_out  <= '0;
      alu_target_out <= '0;
      pc_out         <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        op_q[i]     <= '0;
        tagx_q[i]   <= '0;
        tagy_q[i]   <= '0;
        tagw_q[i]   <= '0;
        datax_q[i]  <= '0;
        datay_q[i]  <= '0;
        target_q[i] <= '0;
        pc_q[i]     <= '0;
      end
    end else if (rdy) begin
      if (flush_in) begin
        valid_q      <= '0;
        full_out     <= 1'b0;
        alu_busy_out <= 1'b0;
      end else begin
        for (int i = 0; i < DEPTH; i++) begin
          if (cdb_en_in && valid_q[i]) begin
            if (tagx_q[i] == cdb_tag_in) begin
              tagx_q[i]  <= '0;
              datax_q[i] <= cdb_data_in;
            end
            if (tagy_q[i] == cdb_tag_in) begin
              tagy_q[i]  <= '0;
              datay_q[i] <= cdb_data_in;
            end
            if (tagw_q[i] == cdb_tag_in) tagw_q[i] <= '0;
          end
        end
        alu_busy_out <= issue_found;
        if (issue_found) begin
          alu_op_out     <= op_q[issue_idx];
          alu_datax_out  <= datax_q[issue_idx];
          alu_datay_out  <= datay_q[issue_idx];
          alu_target_out <= target_q[issue_idx];
          pc_out         <= pc_q[issue_idx];
        end
        // The target slot is invalid, so this write never collides with a wakeup.
        if (alloc_ok) begin
          op_q[alloc_idx]     <= alloc_op_in;
          tagx_q[alloc_idx]   <= hit_x ? '0 : alloc_tagx_in;
          tagy_q[alloc_idx]   <= hit_y ? '0 : alloc_tagy_in;
          tagw_q[alloc_idx]   <= hit_w ? '0 : alloc_tagw_in;
          datax_q[alloc_idx]  <= hit_x ? cdb_data_in : alloc_datax_in;
          datay_q[alloc_idx]  <= hit_y ? cdb_data_in : alloc_datay_in;
          target_q[alloc_idx] <= alloc_target_in;
          pc_q[alloc_idx]     <= alloc_pc_in;
        end
        valid_q  <= valid_nxt;
        full_out <= &valid_nxt;
      end
    end
  end

endmodule

// File: tb/tb_ex_alu_rs.sv
// Bench for ex_alu_rs: directed scenarios plus random traffic, every output
// checked each cycle against a behavioural model of the station.
module tb_ex_alu_rs;

  logic        clk = 1'b0;
  logic        rst, rdy;
  logic        alloc_en_in;
  logic [5:0]  alloc_op_in;
  logic [3:0]  alloc_tagx_in, alloc_tagy_in, alloc_tagw_in;
  logic [31:0] alloc_datax_in, alloc_datay_in, alloc_pc_in;
  logic [4:0]  alloc_target_in;
  logic        full_out;
  logic        cdb_en_in;
  logic [3:0]  cdb_tag_in;
  logic [31:0] cdb_data_in;
  logic        flush_in;
  logic        alu_busy_out;
  logic [5:0]  alu_op_out;
  logic [3:0]  alu_tagx_out, alu_tagy_out, alu_tagw_out;
  logic [31:0] alu_datax_out, alu_datay_out, pc_out;
  logic [4:0]  alu_target_out;

  ex_alu_rs dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .alloc_en_in(alloc_en_in), .alloc_op_in(alloc_op_in),
    .alloc_tagx_in(alloc_tagx_in), .alloc_tagy_in(alloc_tagy_in), .alloc_tagw_in(alloc_tagw_in),
    .alloc_datax_in(alloc_datax_in), .alloc_datay_in(alloc_datay_in),
    .alloc_target_in(alloc_target_in), .alloc_pc_in(alloc_pc_in),
    .full_out(full_out),
    .cdb_en_in(cdb_en_in), .cdb_tag_in(cdb_tag_in), .cdb_data_in(cdb_data_in),
    .flush_in(flush_in),
    .alu_busy_out(alu_busy_out), .alu_op_out(alu_op_out),
    .alu_tagx_out(alu_tagx_out), .alu_tagy_out(alu_tagy_out), .alu_tagw_out(alu_tagw_out),
    .alu_datax_out(alu_datax_out), .alu_datay_out(alu_datay_out),
    .alu_target_out(alu_target_out), .pc_out(pc_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit        v;
    bit [5:0]  op;
    bit [3:0]  tx, ty, tw;
    bit [31:0] dx, dy, pc;
    bit [4:0]  tg;
  } ent_t;

  ent_t      m[4];
  bit        m_busy, m_full;
  bit [5:0]  m_op;
  bit [31:0] m_dx, m_dy, m_pc;
  bit [4:0]  m_tg;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m[i] = '{default: '0};
    m_busy = 0; m_full = 0; m_op = 0; m_dx = 0; m_dy = 0; m_pc = 0; m_tg = 0;
  endtask

  // One clock edge of the station, evaluated from the pre-edge model state.
  task automatic model_edge();
    int sel, slot;
    ent_t e;
    if (!rdy) return;
    if (flush_in) begin
      for (int i = 0; i < 4; i++) m[i].v = 0;
      m_busy = 0;
      m_full = 0;
      return;
    end
    sel = -1;
    slot = -1;
    for (int i = 0; i < 4; i++)
      if (sel < 0 && m[i].v && m[i].tx == 0 && m[i].ty == 0 && m[i].tw == 0) sel = i;
    if (alloc_en_in && !m_full)
      for (int i = 0; i < 4; i++) if (slot < 0 && !m[i].v) slot = i;
    if (cdb_en_in)
      for (int i = 0; i < 4; i++) if (m[i].v) begin
        if (m[i].tx == cdb_tag_in) begin m[i].tx = 0; m[i].dx = cdb_data_in; end
        if (m[i].ty == cdb_tag_in) begin m[i].ty = 0; m[i].dy = cdb_data_in; end
        if (m[i].tw == cdb_tag_in) m[i].tw = 0;
      end
    m_busy = (sel >= 0);
    if (sel >= 0) begin
      m_op = m[sel].op; m_dx = m[sel].dx; m_dy = m[sel].dy;
      m_tg = m[sel].tg; m_pc = m[sel].pc;
      m[sel].v = 0;
    end
    if (slot >= 0) begin
      e.v = 1; e.op = alloc_op_in; e.tg = alloc_target_in; e.pc = alloc_pc_in;
      e.tx = alloc_tagx_in; e.ty = alloc_tagy_in; e.tw = alloc_tagw_in;
      e.dx = alloc_datax_in; e.dy = alloc_datay_in;
      if (cdb_en_in && e.tx == cdb_tag_in) begin e.tx = 0; e.dx = cdb_data_in; end
      if (cdb_en_in && e.ty == cdb_tag_in) begin e.ty = 0; e.dy = cdb_data_in; end
      if (cdb_en_in && e.tw == cdb_tag_in) e.tw = 0;
      m[slot] = e;
    end
    m_full = m[0].v && m[1].v && m[2].v && m[3].v;
  endtask

  task automatic compare_all();
    check("busy",   alu_busy_out,   m_busy);
    check("full",   full_out,       m_full);
    check("op",     alu_op_out,     m_op);
    check("datax",  alu_datax_out,  m_dx);
    check("datay",  alu_datay_out,  m_dy);
    check("target", alu_target_out, m_tg);
    check("pc",     pc_out,         m_pc);
    check("tagx",   alu_tagx_out,   0);
    check("tagy",   alu_tagy_out,   0);
    check("tagw",   alu_tagw_out,   0);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic idle_in();
    rdy = 1; alloc_en_in = 0; cdb_en_in = 0; flush_in = 0;
    cdb_tag_in = 0; cdb_data_in = 0;
  endtask

  task automatic set_alloc(input bit [5:0] op, input bit [3:0] tx, input bit [3:0] ty,
                           input bit [3:0] tw, input bit [31:0] dx, input bit [31:0] dy,
                           input bit [4:0] tg, input bit [31:0] pc);
    alloc_en_in = 1; alloc_op_in = op;
    alloc_tagx_in = tx; alloc_tagy_in = ty; alloc_tagw_in = tw;
    alloc_datax_in = dx; alloc_datay_in = dy; alloc_target_in = tg; alloc_pc_in = pc;
  endtask

  task automatic bcast(input bit [3:0] tag, input bit [31:0] data);
    cdb_en_in = 1; cdb_tag_in = tag; cdb_data_in = data;
  endtask

  function automatic bit [3:0] rtag();
    return ($urandom_range(0, 9) < 6) ? 4'd0 : 4'($urandom_range(1, 7));
  endfunction

  initial begin
    rst = 1;
    idle_in();
    set_alloc(0, 0, 0, 0, 0, 0, 0, 0);
    alloc_en_in = 0;
    model_reset();
    #12;
    compare_all();
    rst = 0;

    // Ready ADD issues one cycle after allocation, then busy drops.
    set_alloc(6'h01, 0, 0, 0, 32'd5, 32'd7, 5'd3, 32'h40);
    step();
    idle_in();
    step();
    check("add_busy", alu_busy_out, 1);
    check("add_datax", alu_datax_out, 5);
    check("add_datay", alu_datay_out, 7);
    check("add_target", alu_target_out, 3);
    step();
    check("add_busy_drop", alu_busy_out, 0);

    // Locked operand waits for its broadcast.
    set_alloc(6'h02, 4'd2, 0, 0, 32'hffff, 32'd1, 5'd4, 32'h44);
    step();
    idle_in();
    step();
    step();
    check("locked_no_issue", alu_busy_out, 0);
    bcast(2, 32'h1234);
    step();
    idle_in();
    step();
    check("wake_busy", alu_busy_out, 1);
    check("wake_datax", alu_datax_out, 32'h1234);

    // Fill, drop a fifth alloc, free index 2 and reuse it.
    for (int i = 0; i < 4; i++) begin
      set_alloc(6'(i + 8), (i == 3) ? 4'd2 : 4'(i + 1), 0, 0, $urandom, $urandom,
                5'(i), 32'h100 + 32'(4 * i));
      step();
    end
    check("full_set", full_out, 1);
    set_alloc(6'h3f, 0, 0, 0, 1, 2, 5'd9, 32'hbad);
    step();
    idle_in();
    step();
    check("dropped_no_issue", alu_busy_out, 0);
    bcast(3, 32'h33);
    step();
    idle_in();
    step();
    check("idx2_issue_pc", pc_out, 32'h108);
    check("full_drop", full_out, 0);
    set_alloc(6'h11, 4'd5, 0, 0, 0, 0, 5'd7, 32'h200);
    step();
    idle_in();
    check("refill_full", full_out, 1);
    bcast(2, 32'h22);
    step();
    idle_in();
    step();
    check("tie_low_first", pc_out, 32'h104);
    step();
    check("tie_high_next", pc_out, 32'h10c);
    check("tie_busy_back2back", alu_busy_out, 1);
    bcast(5, 32'h55);
    step();
    bcast(1, 32'h11);
    step();
    idle_in();
    step();
    step();

    // Same-cycle broadcast bypass into a new entry.
    set_alloc(6'h05, 0, 4'd5, 0, 32'd9, 32'h0, 5'd1, 32'h250);
    bcast(5, 32'hdead);
    step();
    idle_in();
    step();
    check("bypass_busy", alu_busy_out, 1);
    check("bypass_datay", alu_datay_out, 32'hdead);

    // Flush beats a same-cycle alloc.
    for (int i = 0; i < 3; i++) begin
      set_alloc(6'h06, 4'd6, 0, 0, 0, 0, 5'd2, 32'h280 + 32'(i));
      step();
    end
    set_alloc(6'h07, 0, 0, 0, 0, 0, 5'd2, 32'h290);
    flush_in = 1;
    step();
    idle_in();
    check("flush_full", full_out, 0);
    bcast(6, 32'h66);
    step();
    idle_in();
    step();
    check("flush_no_issue", alu_busy_out, 0);
    step();

    // rdy low freezes a live busy pulse.
    set_alloc(6'h08, 0, 0, 0, 1, 1, 5'd1, 32'h300);
    step();
    set_alloc(6'h09, 0, 0, 0, 2, 2, 5'd2, 32'h304);
    step();
    idle_in();
    rdy = 0;
    bcast(1, 32'h77);
    for (int i = 0; i < 3; i++) begin
      step();
      check("hold_busy", alu_busy_out, 1);
      check("hold_pc", pc_out, 32'h300);
    end
    idle_in();
    step();
    check("resume_pc", pc_out, 32'h304);
    step();

    // Random traffic against the model, with one asynchronous reset midway.
    for (int c = 0; c < 3000; c++) begin
      rdy = ($urandom_range(0, 9) != 0);
      alloc_en_in = $urandom_range(0, 1);
      alloc_op_in = 6'($urandom);
      alloc_tagx_in = rtag();
      alloc_tagy_in = rtag();
      alloc_tagw_in = rtag();
      alloc_datax_in = $urandom;
      alloc_datay_in = $urandom;
      alloc_target_in = 5'($urandom);
      alloc_pc_in = $urandom;
      cdb_en_in = ($urandom_range(0, 9) < 5);
      cdb_tag_in = 4'($urandom_range(1, 7));
      cdb_data_in = $urandom;
      flush_in = ($urandom_range(0, 49) == 0);
      step();
      if (c == 1500) begin
        rst = 1;
        #1;
        model_reset();
        compare_all();
        #1 rst = 0;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
